// File: rtl/id_stage_pipelined.sv
// ---------------------------------------------------------------------------
// id_stage_pipelined
//   Instruction-decode stage of the 5-stage MIPS datapath. Holds the register
//   file, extends the 16-bit immediate, resolves beq/bne in ID, detects
//   load-use and branch-operand hazards, and drives the registered ID/EX
//   pipeline slot (bubble/flush capable) plus the IF stall/redirect controls.
//
// Ports
//   Clock, Reset_n            rising-edge clock, asynchronous active-low reset
//   Instruction, PCPlusFour   IF/ID instruction word and its PC+4
//   InValid                   IF/ID slot holds a real instruction
//   CtrlIn                    opaque EX/MEM/WB control bundle
//   RegWriteIn, RegDstIn      destination write enable / rd-vs-rt select
//   IsLoadIn, UsesRtIn        load marker / instruction reads rt
//   IsBranchIn, BranchNeIn    beq/bne marker, 1 = bne
//   SignExtIn                 1 = sign-extend imm16, 0 = zero-extend
//   ExMemRegWrite, ExMemDest  pending write in EX/MEM (branch hazard check)
//   RegWrite, rDestSelected,
//   regWriteData              write-back port into the register file
//   Flush                     squash the instruction currently in ID
//   Stall_PC_output,
//   Stall_IFID_output         hold PC and IF/ID this cycle
//   PCSel_output,
//   BranchTarget_output       combinational branch redirect and target
//   *_output (ID/EX)          registered decode results, 1-cycle latency
//   StallCount_output         saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_stage_pipelined #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic [31:0]       Instruction,
   input  logic [31:0]       PCPlusFour,
   input  logic              InValid,
   input  logic [CTRL_W-1:0] CtrlIn,
   input  logic              RegWriteIn,
   input  logic              RegDstIn,
   input  logic              IsLoadIn,
   input  logic              UsesRtIn,
   input  logic              IsBranchIn,
   input  logic              BranchNeIn,
   input  logic              SignExtIn,
   input  logic              ExMemRegWrite,
   input  logic [ADDR_W-1:0] ExMemDest,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] rDestSelected,
   input  logic [DATA_W-1:0] regWriteData,
   input  logic              Flush,
   output logic              Stall_PC_output,
   output logic              Stall_IFID_output,
   output logic              PCSel_output,
   output logic [31:0]       BranchTarget_output,
   output logic              Valid_output,
   output logic [CTRL_W-1:0] Ctrl_output,
   output logic              RegWrite_output,
   output logic              IsLoad_output,
   output logic [DATA_W-1:0] Reg_Data1_output,
   output logic [DATA_W-1:0] Reg_Data2_output,
   output logic [DATA_W-1:0] Imm32b_output,
   output logic [ADDR_W-1:0] Rs_output,
   output logic [ADDR_W-1:0] Rt_output,
   output logic [ADDR_W-1:0] Dest_output,
   output logic [CNT_W-1:0]  StallCount_output
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic sext);
      logic signed [15:0] imm_s;
      imm_s = $signed(imm);
      return sext ? DATA_W'(imm_s) : DATA_W'(imm);
   endfunction

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic [ADDR_W-1:0]   rs, rt, rd, dest;
   logic [15:0]         imm16;
   logic signed [31:0]  br_off;
   logic signed [DATA_W-1:0] data1, data2;
   logic                rt_used, hit_idex, hit_exmem;
   logic                load_use, br_haz, stall, taken, bubble;

   logic                vld_p1, regwrite_p1, isload_p1;
   logic [CTRL_W-1:0]   ctrl_p1;
   logic [DATA_W-1:0]   data1_p1, data2_p1, imm_p1;
   logic [ADDR_W-1:0]   rs_p1, rt_p1, dest_p1;
   logic [CNT_W-1:0]    stall_cnt;

   assign rs    = Instruction[21 +: ADDR_W];
   assign rt    = Instruction[16 +: ADDR_W];
   assign rd    = Instruction[11 +: ADDR_W];
   assign imm16 = Instruction[15:0];
   assign dest  = !RegWriteIn ? '0 : (RegDstIn ? rd : rt);

   // Register file; entry 0 is never written so it always holds zero.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (RegWrite && rDestSelected != '0) begin
         regs[rDestSelected] <= regWriteData;
      end
   end

   // Reads see the write-back value in the same cycle it is being written.
   always_comb begin
      data1 = $signed(regs[rs]);
      if (RegWrite && rDestSelected == rs) data1 = $signed(regWriteData);
      if (rs == '0) data1 = '0;
      data2 = $signed(regs[rt]);
      if (RegWrite && rDestSelected == rt) data2 = $signed(regWriteData);
      if (rt == '0) data2 = '0;
   end

   // rt only counts as a source when the instruction actually reads it.
   assign rt_used   = UsesRtIn || IsBranchIn;
   assign hit_idex  = (dest_p1 == rs) || (rt_used && dest_p1 == rt);
   assign hit_exmem = (ExMemDest == rs) || (rt_used && ExMemDest == rt);

   assign load_use = vld_p1 && isload_p1 && dest_p1 != '0 && hit_idex;
   // No EX->ID forwarding: a branch waits until its operands reach the regfile.
   assign br_haz   = IsBranchIn && ((vld_p1 && regwrite_p1 && hit_idex) ||
                                    (ExMemRegWrite && ExMemDest != '0 && hit_exmem));
   assign stall    = InValid && !Flush && (load_use || br_haz);
   assign taken    = InValid && IsBranchIn && !stall && !Flush &&
                     ((data1 == data2) ^ BranchNeIn);
   assign bubble   = stall || Flush;

   assign br_off              = 32'($signed(imm16)) <<< 2;
   assign BranchTarget_output = PCPlusFour + $unsigned(br_off);
   assign PCSel_output        = taken;
   assign Stall_PC_output     = stall;
   assign Stall_IFID_output   = stall;

   // ---- ID -> EX boundary ----
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_p1      <= 1'b0;
         regwrite_p1 <= 1'b0;
         isload_p1   <= 1'b0;
         ctrl_p1     <= '0;
         data1_p1    <= '0;
         data2_p1    <= '0;
         imm_p1      <= '0;
         rs_p1       <= '0;
         rt_p1       <= '0;
         dest_p1     <= '0;
         stall_cnt   <= '0;
      end else begin
         if (bubble) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            isload_p1   <= 1'b0;
            ctrl_p1     <= '0;
            data1_p1    <= '0;
            data2_p1    <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            dest_p1     <= '0;
         end else begin
            vld_p1      <= InValid;
            regwrite_p1 <= RegWriteIn;
            isload_p1   <= IsLoadIn;
            ctrl_p1     <= CtrlIn;
            data1_p1    <= $unsigned(data1);
            data2_p1    <= $unsigned(data2);
            imm_p1      <= ext_imm(imm16, SignExtIn);
            rs_p1       <= rs;
            rt_p1       <= rt;
            dest_p1     <= dest;
         end
         if (stall) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign Valid_output      = vld_p1;
   assign Ctrl_output       = ctrl_p1;
   assign RegWrite_output   = regwrite_p1;
   assign IsLoad_output     = isload_p1;
   assign Reg_Data1_output  = data1_p1;
   assign Reg_Data2_output  = data2_p1;
   assign Imm32b_output     = imm_p1;
   assign Rs_output         = rs_p1;
   assign Rt_output         = rt_p1;
   assign Dest_output       = dest_p1;
   assign StallCount_output = stall_cnt;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipelined
//   Scoreboard bench for id_stage_pipelined (2-bit stall counter so that
//   saturation is reachable). The driver applies inputs 2 time units after
//   each rising edge, evaluates a behavioural model and queues the expected
//   combinational and ID/EX results; a monitor on the falling edge pops and
//   compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_id_stage_pipelined;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b1;
   logic [31:0] instr, pc4;
   logic        in_valid;
   logic [15:0] ctrl;
   logic        rw_in, rdst_in, ld_in, usesrt_in, br_in, bne_in, sext_in;
   logic        exm_rw;
   logic [4:0]  exm_dest;
   logic        wb_we;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        flush;

   logic        stall_pc, stall_ifid, pcsel;
   logic [31:0] tgt;
   logic        v_o, rw_o, ld_o;
   logic [15:0] ctrl_o;
   logic [31:0] d1_o, d2_o, imm_o;
   logic [4:0]  rs_o, rt_o, dest_o;
   logic [1:0]  cnt_o;

   id_stage_pipelined #(.DATA_W(32), .ADDR_W(5), .CTRL_W(16), .CNT_W(2)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Instruction(instr), .PCPlusFour(pc4),
      .InValid(in_valid), .CtrlIn(ctrl), .RegWriteIn(rw_in), .RegDstIn(rdst_in),
      .IsLoadIn(ld_in), .UsesRtIn(usesrt_in), .IsBranchIn(br_in), .BranchNeIn(bne_in),
      .SignExtIn(sext_in), .ExMemRegWrite(exm_rw), .ExMemDest(exm_dest),
      .RegWrite(wb_we), .rDestSelected(wb_dest), .regWriteData(wb_data), .Flush(flush),
      .Stall_PC_output(stall_pc), .Stall_IFID_output(stall_ifid), .PCSel_output(pcsel),
      .BranchTarget_output(tgt), .Valid_output(v_o), .Ctrl_output(ctrl_o),
      .RegWrite_output(rw_o), .IsLoad_output(ld_o), .Reg_Data1_output(d1_o),
      .Reg_Data2_output(d2_o), .Imm32b_output(imm_o), .Rs_output(rs_o), .Rt_output(rt_o),
      .Dest_output(dest_o), .StallCount_output(cnt_o)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic        valid;
      logic [15:0] ctrl;
      logic        rw;
      logic        ld;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [1:0]  cnt;
   } idex_t;

   typedef struct packed {
      logic        stall;
      logic        pcsel;
      logic [31:0] tgt;
   } comb_t;

   idex_t       reg_q[$];
   comb_t       comb_q[$];

   // Reference model state
   logic [31:0] m_regs [32];
   idex_t       m_ex, m_next;
   logic        m_we, m_pending;
   logic [4:0]  m_wd;
   logic [31:0] m_wdata;

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] rf(input logic [4:0] i);
      if (i == 5'd0) return 32'd0;
      if (wb_we && wb_dest == i) return wb_data;
      return m_regs[i];
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
      return {6'd0, rs, rt, imm};
   endfunction

   task automatic eval(input bit push_comb);
      logic [4:0]  rs, rt, rd;
      logic [31:0] d1, d2;
      bit          uses, hit_ex, hit_mem, lu, bh, st, tk;
      comb_t       c;
      rs   = instr[25:21];
      rt   = instr[20:16];
      rd   = instr[15:11];
      d1   = rf(rs);
      d2   = rf(rt);
      uses = usesrt_in || br_in;
      hit_ex  = (m_ex.dest == rs) || (uses && m_ex.dest == rt);
      hit_mem = (exm_dest == rs) || (uses && exm_dest == rt);
      lu = m_ex.valid && m_ex.ld && (m_ex.dest != 0) && hit_ex;
      bh = br_in && ((m_ex.valid && m_ex.rw && hit_ex) ||
                     (exm_rw && exm_dest != 0 && hit_mem));
      st = in_valid && !flush && (lu || bh);
      tk = in_valid && br_in && !st && !flush && ((d1 == d2) != bne_in);
      c.stall = st;
      c.pcsel = tk;
      c.tgt   = pc4 + 32'(int'($signed(instr[15:0])) * 4);
      m_next = '0;
      if (!(st || flush)) begin
         m_next.valid = in_valid;
         m_next.ctrl  = ctrl;
         m_next.rw    = rw_in;
         m_next.ld    = ld_in;
         m_next.d1    = d1;
         m_next.d2    = d2;
         m_next.imm   = sext_in ? 32'(int'($signed(instr[15:0]))) : {16'd0, instr[15:0]};
         m_next.rs    = rs;
         m_next.rt    = rt;
         m_next.dest  = !rw_in ? 5'd0 : (rdst_in ? rd : rt);
      end
      m_next.cnt = st ? ((m_ex.cnt == 2'd3) ? 2'd3 : m_ex.cnt + 2'd1) : m_ex.cnt;
      m_we    = wb_we && wb_dest != 0;
      m_wd    = wb_dest;
      m_wdata = wb_data;
      m_pending = 1'b1;
      if (push_comb) comb_q.push_back(c);
   endtask

   // Advance to just after the next rising edge and retire the model.
   task automatic next_cycle();
      @(posedge Clock);
      if (m_pending) begin
         if (m_we) m_regs[m_wd] = m_wdata;
         m_ex = m_next;
         reg_q.push_back(m_next);
      end
      #2;
   endtask

   task automatic set_idle();
      instr = 32'd0; pc4 = 32'd0; in_valid = 1'b0; ctrl = 16'd0;
      rw_in = 1'b0; rdst_in = 1'b0; ld_in = 1'b0; usesrt_in = 1'b0;
      br_in = 1'b0; bne_in = 1'b0; sext_in = 1'b0; exm_rw = 1'b0; exm_dest = 5'd0;
      wb_we = 1'b0; wb_dest = 5'd0; wb_data = 32'd0; flush = 1'b0;
   endtask

   task automatic drive_lw(input logic [4:0] dst);
      set_idle();
      instr = mk(5'd1, dst, 16'h0010); in_valid = 1'b1; ctrl = 16'hA5A5;
      rw_in = 1'b1; ld_in = 1'b1; sext_in = 1'b1;
   endtask

   task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      set_idle();
      instr = mk(rs, rt, {rd, 11'd32}); in_valid = 1'b1; ctrl = 16'h0042;
      rw_in = 1'b1; rdst_in = 1'b1; usesrt_in = 1'b1;
   endtask

   task automatic drive_br(input logic [4:0] rs, input logic [4:0] rt, input logic ne,
                           input logic [15:0] imm, input logic [31:0] pc);
      set_idle();
      instr = mk(rs, rt, imm); pc4 = pc; in_valid = 1'b1; ctrl = 16'h0100;
      br_in = 1'b1; bne_in = ne; sext_in = 1'b1; usesrt_in = 1'b1;
   endtask

   task automatic do_reset();
      comb_q.delete();
      reg_q.delete();
      Reset_n = 1'b0;
      #1;
      chk("rst_valid", 32'(v_o), 32'd0);
      chk("rst_ctrl", 32'(ctrl_o), 32'd0);
      chk("rst_regwrite", 32'(rw_o), 32'd0);
      chk("rst_isload", 32'(ld_o), 32'd0);
      chk("rst_data1", d1_o, 32'd0);
      chk("rst_data2", d2_o, 32'd0);
      chk("rst_imm", imm_o, 32'd0);
      chk("rst_dest", 32'(dest_o), 32'd0);
      chk("rst_cnt", 32'(cnt_o), 32'd0);
      chk("rst_stall_pc", 32'(stall_pc), 32'd0);
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ex = '0;
      m_pending = 1'b0;
      set_idle();
      @(negedge Clock);
      #2;
      Reset_n = 1'b1;
      eval(1'b0);
   endtask

   // Monitor: ID/EX results appear every cycle; compare them and the
   // combinational controls on the falling edge.
   always @(negedge Clock) begin
      if (reg_q.size() > 0) begin
         idex_t e;
         e = reg_q.pop_front();
         chk("idex_valid", 32'(v_o), 32'(e.valid));
         chk("idex_ctrl", 32'(ctrl_o), 32'(e.ctrl));
         chk("idex_regwrite", 32'(rw_o), 32'(e.rw));
         chk("idex_isload", 32'(ld_o), 32'(e.ld));
         chk("idex_data1", d1_o, e.d1);
         chk("idex_data2", d2_o, e.d2);
         chk("idex_imm", imm_o, e.imm);
         chk("idex_rs", 32'(rs_o), 32'(e.rs));
         chk("idex_rt", 32'(rt_o), 32'(e.rt));
         chk("idex_dest", 32'(dest_o), 32'(e.dest));
         chk("stall_count", 32'(cnt_o), 32'(e.cnt));
      end
      if (comb_q.size() > 0) begin
         comb_t c;
         c = comb_q.pop_front();
         chk("stall_pc", 32'(stall_pc), 32'(c.stall));
         chk("stall_ifid", 32'(stall_ifid), 32'(c.stall));
         chk("pcsel", 32'(pcsel), 32'(c.pcsel));
         chk("br_target", tgt, c.tgt);
      end
   end

   initial begin
      set_idle();
      m_ex = '0;
      m_pending = 1'b0;
      #2;
      do_reset();

      // WB write-through bypass, then a write to r0 that must read back as 0
      next_cycle();
      set_idle(); instr = mk(5'd5, 5'd0, 16'd0); in_valid = 1'b1;
      wb_we = 1'b1; wb_dest = 5'd5; wb_data = 32'h1234; eval(1'b1);
      next_cycle();
      chk("t1_bypass", d1_o, 32'h1234);
      set_idle(); instr = mk(5'd0, 5'd0, 16'd0); in_valid = 1'b1;
      wb_we = 1'b1; wb_dest = 5'd0; wb_data = 32'hDEAD; eval(1'b1);
      next_cycle();
      chk("t1_r0", d1_o, 32'd0);

      // beq/bne with equal operands and a negative offset
      set_idle(); wb_we = 1'b1; wb_dest = 5'd1; wb_data = 32'd7; eval(1'b1);
      next_cycle();
      set_idle(); wb_we = 1'b1; wb_dest = 5'd2; wb_data = 32'd7; eval(1'b1);
      next_cycle();
      drive_br(5'd1, 5'd2, 1'b0, 16'hFFFE, 32'h100); eval(1'b1);
      #1;
      chk("t4_beq_pcsel", 32'(pcsel), 32'd1);
      chk("t4_target", tgt, 32'h0F8);
      next_cycle();
      drive_br(5'd1, 5'd2, 1'b1, 16'hFFFE, 32'h100); eval(1'b1);
      #1;
      chk("t4_bne_pcsel", 32'(pcsel), 32'd0);

      // load-use: exactly one bubble
      next_cycle();
      drive_lw(5'd3); eval(1'b1);
      next_cycle();
      drive_add(5'd4, 5'd3, 5'd1); eval(1'b1);
      #1;
      chk("t2_stall", 32'(stall_pc), 32'd1);
      next_cycle();
      chk("t2_bubble", 32'(v_o), 32'd0);
      chk("t2_count", 32'(cnt_o), 32'd1);
      drive_add(5'd4, 5'd3, 5'd1); eval(1'b1);
      #1;
      chk("t2_released", 32'(stall_pc), 32'd0);

      // load followed by dependent branch: two stall cycles
      next_cycle();
      do_reset();
      next_cycle();
      drive_lw(5'd3); eval(1'b1);
      next_cycle();
      drive_br(5'd3, 5'd0, 1'b0, 16'h0004, 32'h200); eval(1'b1);
      #1;
      chk("t3_stall1", 32'(stall_pc), 32'd1);
      next_cycle();
      drive_br(5'd3, 5'd0, 1'b0, 16'h0004, 32'h200);
      exm_rw = 1'b1; exm_dest = 5'd3; eval(1'b1);
      #1;
      chk("t3_stall2", 32'(stall_pc), 32'd1);
      next_cycle();
      drive_br(5'd3, 5'd0, 1'b0, 16'h0004, 32'h200); eval(1'b1);
      #1;
      chk("t3_pcsel", 32'(pcsel), 32'd1);
      chk("t3_count", 32'(cnt_o), 32'd2);

      // flush during a load-use hazard
      next_cycle();
      drive_lw(5'd3); eval(1'b1);
      next_cycle();
      drive_add(5'd4, 5'd3, 5'd1); flush = 1'b1; eval(1'b1);
      #1;
      chk("t5_stall", 32'(stall_pc), 32'd0);
      chk("t5_pcsel", 32'(pcsel), 32'd0);
      next_cycle();
      chk("t5_bubble", 32'(v_o), 32'd0);
      chk("t5_count", 32'(cnt_o), 32'd2);

      // counter saturates at 3 with a 2-bit counter
      for (int k = 0; k < 2; k++) begin
         set_idle(); eval(1'b1);
         next_cycle();
         drive_lw(5'd6); eval(1'b1);
         next_cycle();
         drive_add(5'd7, 5'd1, 5'd6); eval(1'b1);
         next_cycle();
         set_idle(); eval(1'b1);
         next_cycle();
      end
      chk("t6_saturate", 32'(cnt_o), 32'd3);

      // asynchronous reset while a stall is being signalled
      drive_lw(5'd3); eval(1'b1);
      next_cycle();
      drive_add(5'd4, 5'd3, 5'd1); eval(1'b1);
      #1;
      chk("t6_stall_before_rst", 32'(stall_pc), 32'd1);
      do_reset();
      next_cycle();
      drive_add(5'd4, 5'd3, 5'd1); eval(1'b1);
      #1;
      chk("t6_normal_after_rst", 32'(stall_pc), 32'd0);

      // randomized traffic with a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         next_cycle();
         instr          = $urandom;
         instr[25:21]   = 5'($urandom_range(0, 7));
         instr[20:16]   = 5'($urandom_range(0, 7));
         instr[15:11]   = 5'($urandom_range(0, 7));
         pc4            = $urandom & 32'hFFFF_FFFC;
         in_valid       = ($urandom_range(0, 99) < 85);
         ctrl           = 16'($urandom);
         rw_in          = 1'($urandom);
         rdst_in        = 1'($urandom);
         ld_in          = ($urandom_range(0, 99) < 30);
         usesrt_in      = 1'($urandom);
         br_in          = ($urandom_range(0, 99) < 30);
         bne_in         = 1'($urandom);
         sext_in        = 1'($urandom);
         exm_rw         = 1'($urandom);
         exm_dest       = 5'($urandom_range(0, 7));
         wb_we          = 1'($urandom);
         wb_dest        = 5'($urandom_range(0, 7));
         wb_data        = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
         flush          = ($urandom_range(0, 99) < 10);
         eval(1'b1);
      end
      next_cycle();
      set_idle(); eval(1'b1);
      next_cycle();
      @(negedge Clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
